// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul_engine slice: FSM state encoding,
// default dimensions/widths and address-width helpers.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    STORE,
    DONE
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_M      = 8;
  localparam int DEF_K      = 8;
  localparam int DEF_N      = 8;
  localparam int DEF_ACC_W  = 2 * DEF_DATA_W + $clog2(DEF_K);

  // Index width for a RAM of the given depth; never narrower than one bit.
  function automatic int ram_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int addr_w(input int depth_a, input int depth_b);
    return ram_w((depth_a > depth_b) ? depth_a : depth_b);
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Host-side bus of matmul_engine: operand load, run control and C readout.
// master = host, slave = engine.
interface matmul_if
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int M      = DEF_M,
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int ACC_W  = 2 * DATA_W + $clog2(K)
);
  localparam int AW = addr_w(M * K, K * N);
  localparam int RW = ram_w(M * N);

  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [RW-1:0]     rd_addr;
  logic [ACC_W-1:0]  rd_data;
  logic              ovf;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    input  busy, done, rd_data, ovf
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    output busy, done, rd_data, ovf
  );

endinterface

// File: rtl/matmul_engine_mac_unit.sv
// Multiply-accumulate unit with sticky carry-out flag.
// Define MATMUL_SATURATE_EN to clamp the accumulator instead of wrapping.
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              ovf_clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);
  localparam int PW = ACC_W + 1;

  logic [PW-1:0] prod;
  logic [PW-1:0] sum;
  logic          carry;

  // Multiplying in PW bits yields the product zero-extended or truncated to PW.
  assign prod  = PW'(a) * PW'(b);
  assign sum   = {1'b0, acc} + prod;
  assign carry = sum[ACC_W];

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
`ifdef MATMUL_SATURATE_EN
        acc <= carry ? '1 : sum[ACC_W-1:0];
`else
        acc <= sum[ACC_W-1:0];
`endif
      end

      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (en && carry) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// Self-sequenced C = A x B engine with internal A/B/C RAMs and an i/j/k FSM.
// Optional MATMUL_SATURATE_EN (in mac_unit) selects saturating accumulation.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int M      = DEF_M,
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int ACC_W  = 2 * DATA_W + $clog2(K)
) (
  input  logic     clk,
  input  logic     rst,
  matmul_if.slave  bus
);
  localparam int AAW = ram_w(M * K);
  localparam int BAW = ram_w(K * N);
  localparam int CAW = ram_w(M * N);
  localparam int IW  = ram_w(M);
  localparam int JW  = ram_w(N);
  localparam int KW  = ram_w(K);

  state_t state, state_n;

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;

  logic acc_clr, acc_en, c_we, run_go;
  logic busy, done;
  logic last_k, last_j, last_el;
  logic a_we, b_we;

  int             k_rd;
  logic [AAW-1:0] a_raddr;
  logic [BAW-1:0] b_raddr;
  logic [CAW-1:0] c_waddr;

  logic [DATA_W-1:0] a_q, b_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  rd_q;
  logic              ovf;

  logic [DATA_W-1:0] a_mem [2**AAW];
  logic [DATA_W-1:0] b_mem [2**BAW];
  logic [ACC_W-1:0]  c_mem [2**CAW];

  assign last_k  = (int'(k) == K - 1);
  assign last_j  = (int'(j) == N - 1);
  assign last_el = last_j && (int'(i) == M - 1);

  // Operands are writable only while idle; addresses beyond the matrix are dropped.
  assign a_we = (state == IDLE) && bus.wr_en && !bus.wr_sel && (int'(bus.wr_addr) < M * K);
  assign b_we = (state == IDLE) && bus.wr_en &&  bus.wr_sel && (int'(bus.wr_addr) < K * N);

  // CLEAR prefetches k=0; each MAC cycle prefetches k+1 for the next cycle.
  always_comb begin
    k_rd = 0;
    if (state == MAC && !last_k) k_rd = int'(k) + 1;
    a_raddr = AAW'(int'(i) * K + k_rd);
    b_raddr = BAW'(k_rd * N + int'(j));
    c_waddr = CAW'(int'(i) * N + int'(j));
  end

  // NOTE: RAM arrays sit in a block with no reset branch so they map onto
  // plain memories; their contents survive reset by design.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[AAW'(bus.wr_addr)] <= bus.wr_data;
    if (b_we) b_mem[BAW'(bus.wr_addr)] <= bus.wr_data;
    if (c_we) c_mem[c_waddr] <= acc;
    a_q <= a_mem[a_raddr];
    b_q <= b_mem[b_raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= (int'(bus.rd_addr) < M * N) ? c_mem[bus.rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.start) begin
            i <= '0;
            j <= '0;
          end
        end
        CLEAR: k <= '0;
        MAC: begin
          if (!last_k) k <= k + 1'b1;
        end
        STORE: begin
          if (last_j) begin
            j <= '0;
            if (!last_el) i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    c_we    = 1'b0;
    run_go  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          run_go  = 1'b1;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        acc_clr = 1'b1;
        state_n = MAC;
      end
      MAC: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        if (last_k) state_n = STORE;
      end
      STORE: begin
        busy    = 1'b1;
        c_we    = 1'b1;
        state_n = last_el ? DONE : CLEAR;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (acc_en),
    .ovf_clr (run_go),
    .a       (a_q),
    .b       (b_q),
    .acc     (acc),
    .ovf     (ovf)
  );

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rd_data = rd_q;
  assign bus.ovf     = ovf;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: three instances (8x8x8 ACC_W=19,
// 8x8x8 ACC_W=16, 2x3x4) checked against a plain-arithmetic matrix model.
module tb_matmul_engine;
  import matmul_pkg::*;

`ifdef MATMUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        wr_en, wr_sel, start;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;

  logic        busy_s, done_s, ovf_s;
  logic [31:0] rd_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state for the currently selected instance.
  int     cm, ck, cn, acc_w_cur;
  int     a_m [64];
  int     b_m [64];
  longint c_exp [64];
  bit     ovf_exp;

  matmul_if #(.DATA_W(8), .M(8), .K(8), .N(8), .ACC_W(19)) if0 ();
  matmul_if #(.DATA_W(8), .M(8), .K(8), .N(8), .ACC_W(16)) if1 ();
  matmul_if #(.DATA_W(8), .M(2), .K(3), .N(4), .ACC_W(18)) if2 ();

  matmul_engine #(.DATA_W(8), .M(8), .K(8), .N(8), .ACC_W(19)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  matmul_engine #(.DATA_W(8), .M(8), .K(8), .N(8), .ACC_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  matmul_engine #(.DATA_W(8), .M(2), .K(3), .N(4), .ACC_W(18)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.wr_en   = wr_en && (sel == 0);
  assign if0.wr_sel  = wr_sel;
  assign if0.wr_addr = wr_addr[5:0];
  assign if0.wr_data = wr_data;
  assign if0.start   = start && (sel == 0);
  assign if0.rd_addr = rd_addr[5:0];

  assign if1.wr_en   = wr_en && (sel == 1);
  assign if1.wr_sel  = wr_sel;
  assign if1.wr_addr = wr_addr[5:0];
  assign if1.wr_data = wr_data;
  assign if1.start   = start && (sel == 1);
  assign if1.rd_addr = rd_addr[5:0];

  assign if2.wr_en   = wr_en && (sel == 2);
  assign if2.wr_sel  = wr_sel;
  assign if2.wr_addr = wr_addr[3:0];
  assign if2.wr_data = wr_data;
  assign if2.start   = start && (sel == 2);
  assign if2.rd_addr = rd_addr[2:0];

  always_comb begin
    busy_s = if0.busy;
    done_s = if0.done;
    ovf_s  = if0.ovf;
    rd_s   = 32'(if0.rd_data);
    if (sel == 1) begin
      busy_s = if1.busy;
      done_s = if1.done;
      ovf_s  = if1.ovf;
      rd_s   = 32'(if1.rd_data);
    end else if (sel == 2) begin
      busy_s = if2.busy;
      done_s = if2.done;
      ovf_s  = if2.ovf;
      rd_s   = 32'(if2.rd_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic target(input int s);
    sel = s;
    if (s == 2) begin
      cm = 2; ck = 3; cn = 4; acc_w_cur = 18;
    end else begin
      cm = 8; ck = 8; cn = 8; acc_w_cur = (s == 1) ? 16 : 19;
    end
  endtask

  // Plain matrix product with ACC_W-bit wrap or clamp and a carry flag.
  function automatic void compute_model();
    longint lim, acc, s;
    lim = longint'(1) << acc_w_cur;
    ovf_exp = 1'b0;
    for (int r = 0; r < cm; r++) begin
      for (int c = 0; c < cn; c++) begin
        acc = 0;
        for (int x = 0; x < ck; x++) begin
          s = acc + (longint'(a_m[r * ck + x]) * longint'(b_m[x * cn + c])) % (2 * lim);
          if (s >= lim) begin
            ovf_exp = 1'b1;
            acc = SAT ? lim - 1 : s % lim;
          end else begin
            acc = s;
          end
        end
        c_exp[r * cn + c] = acc;
      end
    end
  endfunction

  task automatic wr(input bit s, input int addr, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = s;
    wr_addr = 16'(addr);
    wr_data = 8'(d);
  endtask

  task automatic load();
    for (int x = 0; x < cm * ck; x++) wr(1'b0, x, a_m[x]);
    for (int x = 0; x < ck * cn; x++) wr(1'b1, x, b_m[x]);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a run and watches a fixed window; optionally injects start+write at cycle inj.
  task automatic run(input string tag, input int inj, output bit ovf_c1);
    int len, busy_cnt, done_cnt, done_at, first_busy;
    len = cm * cn * (ck + 2);
    busy_cnt = 0; done_cnt = 0; done_at = -1; first_busy = -1; ovf_c1 = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= len + 4; c++) begin
      if (c == 1) ovf_c1 = ovf_s;
      if (busy_s) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
      end
      if (done_s) begin
        done_cnt++;
        done_at = c;
      end
      if (c == inj) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd99;
      end
      if (c == inj + 1) begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " first busy cycle"}, 64'(first_busy), 64'd1);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(len));
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " done cycle"}, 64'(done_at), 64'(len + 1));
  endtask

  task automatic check_c(input string tag);
    for (int x = 0; x < cm * cn; x++) begin
      @(negedge clk);
      rd_addr = 16'(x);
      @(negedge clk);
      check($sformatf("%s C[%0d]", tag, x), 64'(rd_s), 64'(c_exp[x]));
    end
    check({tag, " ovf"}, 64'(ovf_s), 64'(ovf_exp));
  endtask

  task automatic fill_random(input int hi);
    for (int x = 0; x < 64; x++) begin
      a_m[x] = int'($urandom_range(0, hi));
      b_m[x] = int'($urandom_range(0, hi));
    end
  endtask

  initial begin
    bit ovf_c1;
    int dcnt;
    rst = 1'b0; sel = 0; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    target(0);
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy_s), 64'd0);
    check("reset done", 64'(done_s), 64'd0);
    check("reset ovf", 64'(ovf_s), 64'd0);
    check("reset rd_data", 64'(rd_s), 64'd0);
    rst = 1'b1;

    // Identity A, B[k][j] = 8k+j.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a_m[r * 8 + c] = (r == c) ? 1 : 0;
        b_m[r * 8 + c] = 8 * r + c;
      end
    load();
    compute_model();
    run("ident", -1, ovf_c1);
    check_c("ident");

    // All operands at maximum.
    for (int x = 0; x < 64; x++) begin
      a_m[x] = 255;
      b_m[x] = 255;
    end
    load();
    compute_model();
    run("max19", -1, ovf_c1);
    check_c("max19");

    // Same data into the 16-bit accumulator instance: overflow.
    target(1);
    load();
    compute_model();
    run("max16", -1, ovf_c1);
    check_c("max16");
    check("max16 ovf before rerun", 64'(ovf_s), 64'd1);
    run("max16 rerun", -1, ovf_c1);
    check("max16 ovf cleared by start", 64'(ovf_c1), 64'd0);
    check_c("max16 rerun");

    // Random operands; start + A[0] write injected mid-run must be ignored.
    target(0);
    fill_random(255);
    load();
    compute_model();
    run("proto", 100, ovf_c1);
    check_c("proto");
    run("proto rerun", -1, ovf_c1);
    check_c("proto rerun");

    target(1);
    fill_random(255);
    load();
    compute_model();
    run("rand16", -1, ovf_c1);
    check_c("rand16");

    // Non-square 2x3x4, with out-of-range writes after the load.
    target(2);
    for (int x = 0; x < 6; x++) a_m[x] = x + 1;
    for (int x = 0; x < 12; x++) b_m[x] = 1;
    load();
    for (int x = 6; x < 16; x++) wr(1'b0, x, 200);
    for (int x = 12; x < 16; x++) wr(1'b1, x, 200);
    @(negedge clk);
    wr_en = 1'b0;
    compute_model();
    run("ns", -1, ovf_c1);
    check_c("ns");

    fill_random(255);
    load();
    compute_model();
    run("ns rand", -1, ovf_c1);
    check_c("ns rand");

    // Reset at cycle 300 of a run, then a clean rerun.
    target(0);
    fill_random(255);
    load();
    compute_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (c == 300) rst = 1'b0;
      @(negedge clk);
    end
    check("midrst busy", 64'(busy_s), 64'd0);
    check("midrst done", 64'(done_s), 64'd0);
    rst = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_s || busy_s) dcnt++;
    end
    check("midrst idle after reset", 64'(dcnt), 64'd0);
    run("midrst rerun", -1, ovf_c1);
    check_c("midrst rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
